// File: rtl/u_xmit_arb_pkg.sv
// Shared constants for the transmit arbiter: FSM encoding, timeout default,
// counter width and a small one-hot helper.
package u_xmit_arb_pkg;

    typedef enum logic [1:0] {
        A_IDLE = 2'd0,
        A_SEND = 2'd1,
        A_WAIT = 2'd2
    } arb_state_e;

    localparam int unsigned TIMEOUT_CYC_DFLT = 2048;
    localparam int unsigned CNT_W            = 12;
    localparam int unsigned N_REQ            = 4;

    function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/u_xmit_arb_rr_pick4.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping 3 -> 0.
module rr_pick4 (
    input  logic [3:0] reqH,
    input  logic [1:0] ptr,
    output logic       validH,
    output logic [1:0] winner
);

    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    logic [1:0] offset;

    always_comb begin
        // Doubling the vector lets a plain part-select perform the rotation.
        req_dbl = {reqH, reqH};
        req_rot = req_dbl[ptr +: 4];
        offset  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (req_rot[3 - i]) begin
                offset = 2'(3 - i);
            end
        end
        validH = |reqH;
        winner = ptr + offset;
    end

endmodule

// File: rtl/u_xmit_arb.sv
// Four-requester round-robin arbiter in front of a shared byte transmitter,
// with a watchdog on the transmitter's done handshake.
module u_xmit_arb
    import u_xmit_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DFLT
) (
    input  logic        sys_clk,
    input  logic        sys_rst_l,
    input  logic        arb_enH,
    input  logic [3:0]  reqH,
    input  logic [31:0] req_dataH,
    output logic [3:0]  ackH,
    output logic        xmitH,
    output logic [7:0]  xmit_dataH,
    input  logic        xmit_doneH,
    output logic        busyH,
    output logic        timeout_errH
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_e       state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       winner_q, winner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       ack_q, ack_d;
    logic             xmit_q, xmit_d;
    logic [7:0]       xmit_data_q, xmit_data_d;
    logic             busy_q, busy_d;
    logic             timeout_err_q, timeout_err_d;

    logic             pick_valid;
    logic [1:0]       pick_winner;

    rr_pick4 u_pick (
        .reqH   (reqH),
        .ptr    (ptr_q),
        .validH (pick_valid),
        .winner (pick_winner)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        winner_d      = winner_q;
        cnt_d         = cnt_q;
        ack_d         = '0;
        xmit_d        = 1'b0;
        xmit_data_d   = xmit_data_q;
        timeout_err_d = 1'b0;

        case (state_q)
            A_IDLE: begin
                if (arb_enH && pick_valid) begin
                    state_d     = A_SEND;
                    winner_d    = pick_winner;
                    ack_d       = onehot4(pick_winner);
                    xmit_d      = 1'b1;
                    xmit_data_d = req_dataH[{pick_winner, 3'b000} +: 8];
                end
            end
            A_SEND: begin
                state_d = A_WAIT;
                cnt_d   = '0;
            end
            A_WAIT: begin
                // Done takes priority over a simultaneous timeout.
                if (xmit_doneH) begin
                    state_d = A_IDLE;
                    ptr_d   = winner_q + 2'd1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = A_IDLE;
                    ptr_d         = winner_q + 2'd1;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = A_IDLE;
            end
        endcase

        busy_d = (state_d != A_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_l) begin
            state_q       <= A_IDLE;
            ptr_q         <= '0;
            winner_q      <= '0;
            cnt_q         <= '0;
            ack_q         <= '0;
            xmit_q        <= 1'b0;
            xmit_data_q   <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            winner_q      <= winner_d;
            cnt_q         <= cnt_d;
            ack_q         <= ack_d;
            xmit_q        <= xmit_d;
            xmit_data_q   <= xmit_data_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign ackH         = ack_q;
    assign xmitH        = xmit_q;
    assign xmit_dataH   = xmit_data_q;
    assign busyH        = busy_q;
    assign timeout_errH = timeout_err_q;

endmodule

// File: tb/tb_u_xmit_arb.sv
// Transaction-level bench for u_xmit_arb: directed scenarios plus random
// request/done-delay traffic against a round-robin reference model.
module tb_u_xmit_arb;

    localparam int T = 8;

    logic        sys_clk = 1'b0;
    logic        sys_rst_l;
    logic        arb_enH;
    logic [3:0]  reqH;
    logic [31:0] req_dataH;
    logic [3:0]  ackH;
    logic        xmitH;
    logic [7:0]  xmit_dataH;
    logic        xmit_doneH;
    logic        busyH;
    logic        timeout_errH;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_xmit_cyc = -1;
    int ptr_m = 0;

    u_xmit_arb #(.TIMEOUT_CYC(T)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_l    (sys_rst_l),
        .arb_enH      (arb_enH),
        .reqH         (reqH),
        .req_dataH    (req_dataH),
        .ackH         (ackH),
        .xmitH        (xmitH),
        .xmit_dataH   (xmit_dataH),
        .xmit_doneH   (xmit_doneH),
        .busyH        (busyH),
        .timeout_errH (timeout_errH)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference arbitration: scan from the pointer, wrapping modulo 4.
    function automatic int exp_winner(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // One full transaction. d < T: done returned in the d-th wait cycle;
    // d >= T: done never returned, watchdog expected.
    task automatic txn(input logic [3:0] req, input int d);
        int         w;
        logic [7:0] b;
        logic [3:0] oh;
        w         = exp_winner(req, ptr_m);
        req_dataH = $urandom;
        reqH      = req;
        arb_enH   = 1'b1;
        b         = req_dataH[w*8 +: 8];
        oh        = 4'b0001 << w;
        @(negedge sys_clk);
        chk("ack", ackH, oh);
        chk("xmit", xmitH, 1);
        chk("xmit_data", xmit_dataH, b);
        chk("busy_send", busyH, 1);
        if (last_xmit_cyc >= 0) chk("xmit_gap_ge3", (cyc - last_xmit_cyc) >= 3, 1);
        last_xmit_cyc = cyc;
        reqH      = 4'($urandom);
        req_dataH = $urandom;
        arb_enH   = 1'($urandom_range(0, 1));
        @(negedge sys_clk);
        chk("ack_cleared", ackH, 0);
        chk("xmit_cleared", xmitH, 0);
        chk("busy_wait", busyH, 1);
        if (d < T) begin
            repeat (d) @(negedge sys_clk);
            chk("busy_done_cyc", busyH, 1);
            xmit_doneH = 1'b1;
            reqH       = '0;
            @(negedge sys_clk);
            xmit_doneH = 1'b0;
            chk("busy_after_done", busyH, 0);
            chk("no_timeout", timeout_errH, 0);
            chk("data_held", xmit_dataH, b);
        end else begin
            reqH = '0;
            repeat (T - 1) @(negedge sys_clk);
            chk("busy_last_wait", busyH, 1);
            chk("timeout_early", timeout_errH, 0);
            @(negedge sys_clk);
            chk("timeout_pulse", timeout_errH, 1);
            chk("busy_after_to", busyH, 0);
            xmit_doneH = 1'b1;
            @(negedge sys_clk);
            xmit_doneH = 1'b0;
            chk("timeout_once", timeout_errH, 0);
            chk("stray_done_idle", busyH, 0);
        end
        ptr_m = (w + 1) % 4;
    endtask

    logic [3:0] rr;
    int         dd;
    int         seen;

    initial begin
        sys_rst_l  = 1'b0;
        arb_enH    = 1'b0;
        reqH       = '0;
        req_dataH  = '0;
        xmit_doneH = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_ack", ackH, 0);
        chk("rst_xmit", xmitH, 0);
        chk("rst_data", xmit_dataH, 0);
        chk("rst_busy", busyH, 0);
        chk("rst_timeout", timeout_errH, 0);
        sys_rst_l = 1'b1;
        ptr_m     = 0;
        @(negedge sys_clk);

        for (int i = 0; i < 5; i++) txn(4'b1111, 4);
        txn(4'b0100, 2);
        txn(4'b1111, T);
        txn(4'b1111, 1);
        txn(4'b0011, T - 1);
        txn(4'b1010, 0);
        txn(4'b1010, 0);

        arb_enH = 1'b0;
        reqH    = 4'b0001;
        seen    = 0;
        repeat (100) begin
            @(negedge sys_clk);
            if (ackH != 0 || busyH) seen++;
        end
        chk("no_grant_disabled", seen, 0);
        txn(4'b0001, 3);

        arb_enH = 1'b0;
        reqH    = 4'b1010;
        repeat (3) @(negedge sys_clk);
        reqH    = '0;
        arb_enH = 1'b1;
        seen    = 0;
        repeat (4) begin
            @(negedge sys_clk);
            if (ackH != 0 || busyH) seen++;
        end
        chk("dropped_req_no_ack", seen, 0);

        arb_enH   = 1'b1;
        reqH      = 4'b1000;
        req_dataH = $urandom;
        @(negedge sys_clk);
        chk("pre_rst_ack", ackH, 4'b1000);
        reqH = '0;
        repeat (2) @(negedge sys_clk);
        sys_rst_l = 1'b0;
        @(negedge sys_clk);
        chk("midrst_ack", ackH, 0);
        chk("midrst_xmit", xmitH, 0);
        chk("midrst_data", xmit_dataH, 0);
        chk("midrst_busy", busyH, 0);
        chk("midrst_timeout", timeout_errH, 0);
        sys_rst_l = 1'b1;
        ptr_m     = 0;
        @(negedge sys_clk);
        xmit_doneH = 1'b1;
        @(negedge sys_clk);
        xmit_doneH = 1'b0;
        chk("stray_done_busy", busyH, 0);
        chk("stray_done_to", timeout_errH, 0);
        repeat (T + 2) @(negedge sys_clk);
        chk("no_late_timeout", timeout_errH, 0);
        txn(4'b1111, 2);

        for (int i = 0; i < 80; i++) begin
            rr = 4'($urandom_range(1, 15));
            dd = $urandom_range(0, T + 1);
            txn(rr, dd);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
